bram_wr_arb: RTL and testbench

- Shares the single write port of the operand/result BRAM between two requesters: port 0 (mon_exp result writes) and port 1 (serial_to_parallel operand loads).
- Provides request/grant arbitration with burst locking, round-robin tie-break and a registered write output.
- Sits between both writers and the bram WR_* inputs, so mon_exp cannot corrupt an operand load that is still in flight.

---
 rtl/bram_wr_arb_if.sv | 16 +
 rtl/bram_wr_arb.sv | 140 ++++++++++++++
 tb/tb_bram_wr_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_wr_arb_if.sv
// Write-requester bundle for bram_wr_arb: one instance per port.
// Handshake: req is valid, gnt is ready; a beat transfers in every cycle where both are high.
// addr/data are sampled only on a beat, and last qualifies only a beat.
interface bram_wr_arb_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 256
);
    logic             req;
    logic             last;
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] data;
    logic             gnt;

    modport master (output req, output last, output addr, output data, input gnt);
    modport slave  (input req, input last, input addr, input data, output gnt);
endinterface

// File: rtl/bram_wr_arb.sv
// Two-port write arbiter for the shared BRAM write port: burst locking, round-robin tie-break.
// Optional burst watchdog enabled with `define BRAM_WR_ARB_WDOG_EN.
module bram_wr_arb #(
    parameter int ABITS     = 8,
    parameter int DBITS     = 256,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bram_wr_arb_if.slave     p0,
    bram_wr_arb_if.slave     p1,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             busy,
    output logic             abort,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr_ptr;
    logic   rr_nxt;
    logic   gnt0_q;
    logic   gnt1_q;

    logic   beat0;
    logic   beat1;
    logic   beat;
    logic   beat_last;
    logic   wdog_hit;
    logic   release_own;

    assign beat0       = (state == OWN0) && p0.req;
    assign beat1       = (state == OWN1) && p1.req;
    assign beat        = beat0 || beat1;
    assign beat_last   = beat0 ? p0.last : p1.last;
    // A watchdog hit ends ownership exactly like a last beat would.
    assign release_own = beat && (beat_last || wdog_hit);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (p0.req && p1.req) begin
                    state_nxt = rr_ptr ? OWN1 : OWN0;
                end else if (p0.req) begin
                    state_nxt = OWN0;
                end else if (p1.req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (release_own) begin
                    rr_nxt    = 1'b1;
                    state_nxt = p1.req ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (release_own) begin
                    rr_nxt    = 1'b0;
                    state_nxt = p0.req ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            gnt0_q <= (state_nxt == OWN0);
            gnt1_q <= (state_nxt == OWN1);
        end
    end

    assign p0.gnt    = gnt0_q;
    assign p1.gnt    = gnt1_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Only the owner's beat is captured, so an ungranted port can never reach the BRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= beat;
            if (beat) begin
                wr_addr <= beat0 ? p0.addr : p1.addr;
                wr_data <= beat0 ? p0.data : p1.data;
            end
        end
    end

`ifdef BRAM_WR_ARB_WDOG_EN
    logic [7:0] beat_cnt;
    logic       abort_q;

    // beat_cnt holds the beats already taken in this ownership period.
    assign wdog_hit = beat && !beat_last && (beat_cnt == 8'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 8'd0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= wdog_hit;
            if (release_own || (state == IDLE)) begin
                beat_cnt <= 8'd0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    assign abort = abort_q;
`else
    logic [7:0] unused_max_burst;

    assign unused_max_burst = 8'(MAX_BURST);
    assign wdog_hit         = 1'b0;
    assign abort            = 1'b0;
`endif

endmodule

// File: tb/tb_bram_wr_arb.sv
// Self-checking bench for bram_wr_arb: directed scenarios plus random bursts vs a transaction model.
module tb_bram_wr_arb;
    localparam int AW = 8;
    localparam int DW = 256;
    localparam int MB = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          busy;
    logic          abort;
    logic [1:0]    state_dbg;

    bram_wr_arb_if #(.ABITS(AW), .DBITS(DW)) p0_if ();
    bram_wr_arb_if #(.ABITS(AW), .DBITS(DW)) p1_if ();

    bram_wr_arb #(.ABITS(AW), .DBITS(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .abort     (abort),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int ff_writes;
    int p0_writes;
    int abort_pulses;

    int   m_owner;   // -1 none, else owning port
    int   m_rr;      // port preferred on a tie
    int   m_cnt;     // beats taken in current ownership
    logic m_wr_en;
    logic m_abort;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_cnt   = 0;
        m_wr_en = 1'b0;
        m_abort = 1'b0;
        exp_q.delete();
    endtask

    // One clock of the arbitration rules; results are what the DUT shows next cycle.
    task automatic model_step(input logic r0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic          r[2];
        logic          l[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2];
        int            o;
        bit            done;
        r[0] = r0; l[0] = l0; a[0] = a0; d[0] = d0;
        r[1] = r1; l[1] = l1; a[1] = a1; d[1] = d1;
        m_wr_en = 1'b0;
        m_abort = 1'b0;
        if (m_owner < 0) begin
            if (r[0] && r[1]) m_owner = m_rr;
            else if (r[0]) m_owner = 0;
            else if (r[1]) m_owner = 1;
            m_cnt = 0;
        end else if (r[m_owner]) begin
            o = m_owner;
            m_wr_en = 1'b1;
            exp_q.push_back({a[o], d[o]});
            m_cnt++;
            done = l[o];
`ifdef BRAM_WR_ARB_WDOG_EN
            if (!done && m_cnt == MB) begin
                done    = 1'b1;
                m_abort = 1'b1;
            end
`endif
            if (done) begin
                m_rr    = 1 - o;
                m_owner = r[1-o] ? (1 - o) : -1;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [AW+DW-1:0] e;
        check("gnt0", p0_if.gnt, m_owner == 0);
        check("gnt1", p1_if.gnt, m_owner == 1);
        check("busy", busy, m_owner >= 0);
        check("wr_en", wr_en, m_wr_en);
        check("abort", abort, m_abort);
        if (wr_en === 1'b1 && wr_addr == 8'hFF) ff_writes++;
        if (wr_en === 1'b1 && wr_addr[7:6] == 2'b01) p0_writes++;
        if (abort === 1'b1) abort_pulses++;
        if (m_wr_en) begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e[AW+DW-1:DW]);
            check("wr_data", wr_data, e[DW-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic r0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        p0_if.req = r0; p0_if.last = l0; p0_if.addr = a0; p0_if.data = d0;
        p1_if.req = r1; p1_if.last = l1; p1_if.addr = a1; p1_if.data = d1;
        model_step(r0, l0, a0, d0, r1, l1, a1, d1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, p0_if.gnt, 1'b0);
        check({tag, "_gnt1"}, p1_if.gnt, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_abort"}, abort, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, '0);
        check({tag, "_wr_data"}, wr_data, '0);
    endtask

    // Assert reset mid-cycle; released by the next step().
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst");
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] ones;
    logic [DW-1:0] d_a;
    logic [DW-1:0] d_b;
    int            rem[2];
    logic          rq[2];
    logic          lq[2];
    logic [AW-1:0] aq[2];
    logic [DW-1:0] dq[2];
    int            own;

    initial begin
        ones = '1;
        d_a  = {8{$urandom}};
        d_b  = {8{$urandom}};
        rst_n = 1'b0;
        p0_if.req = 1'b0; p0_if.last = 1'b0; p0_if.addr = '0; p0_if.data = '0;
        p1_if.req = 1'b0; p1_if.last = 1'b0; p1_if.addr = '0; p1_if.data = '0;
        model_reset();
        ff_writes = 0;
        repeat (2) @(negedge clk);
        check_all_zero("init");

        // Single requester, single-beat burst
        step(1'b1, 1'b1, 8'h05, 256'hA5A5, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 8'h05, 256'hA5A5, 1'b0, 1'b0, '0, '0);
        check("single_gnt0_c1", p0_if.gnt, 1'b1);
        idle();
        check("single_wr_en_c2", wr_en, 1'b1);
        check("single_addr_c2", wr_addr, 8'h05);
        check("single_data_c2", wr_data, 256'hA5A5);
        check("single_gnt0_c2", p0_if.gnt, 1'b0);
        idle();

        // Tie after reset goes to port 0, then hand-over to port 1 with no bubble
        do_reset();
        step(1'b1, 1'b0, 8'h10, d_a, 1'b1, 1'b0, 8'h20, d_b);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, (i == 4), 8'(8'h10 + i), d_a ^ DW'(i), 1'b1, 1'b0, 8'h20, d_b);
            check("tie_gnt0", p0_if.gnt, 1'b1);
            if (i > 1) check("tie_wr_en_p0", wr_en, 1'b1);
        end
        for (int j = 1; j <= 3; j++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, (j == 3), 8'(8'h20 + j), d_b ^ DW'(j));
            check("rr_gnt1", p1_if.gnt, 1'b1);
            check("rr_wr_en", wr_en, 1'b1);
        end
        idle();
        idle();

        // Burst lock: port 1 stalls, port 0 waits
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h60, d_b);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h61, d_b);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h62, d_b);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 8'h50, d_a, 1'b0, 1'b1, 8'h6F, d_b);
            check("lock_gnt0", p0_if.gnt, 1'b0);
            if (k > 0) check("lock_wr_en", wr_en, 1'b0);
        end
        step(1'b1, 1'b1, 8'h50, d_a, 1'b1, 1'b0, 8'h63, d_b);
        check("lock_wr_en_end", wr_en, 1'b0);
        step(1'b1, 1'b1, 8'h50, d_a, 1'b1, 1'b1, 8'h64, d_b);
        step(1'b1, 1'b1, 8'h50, d_a, 1'b0, 1'b0, '0, '0);
        check("lock_gnt0_after", p0_if.gnt, 1'b1);
        idle();
        idle();

        // Ungranted isolation: port 1 parks 0xFF / all ones while port 0 writes
        ff_writes = 0;
        step(1'b1, 1'b0, 8'h30, d_a, 1'b0, 1'b1, 8'hFF, ones);
        for (int i = 1; i <= 3; i++)
            step(1'b1, (i == 3), 8'(8'h30 + i), d_a, 1'b0, 1'b1, 8'hFF, ones);
        idle();
        idle();
        check("no_ff_write", ff_writes, 0);

        // Reset mid-burst on port 1
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h70, d_b);
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'(8'h70 + i), d_b);
        do_reset();
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h78, d_b);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h79, d_b);
        check("rst_regrant_gnt1", p1_if.gnt, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h7A, d_b);
        idle();
        idle();

`ifdef BRAM_WR_ARB_WDOG_EN
        // Watchdog: 6-beat stream without last, limit 4
        do_reset();
        p0_writes    = 0;
        abort_pulses = 0;
        step(1'b1, 1'b0, 8'h40, d_a, 1'b1, 1'b0, 8'h80, d_b);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i), d_a, 1'b1, 1'b0, 8'h80, d_b);
            if (i == 5) check("wdog_gnt1_after_beat4", p1_if.gnt, 1'b1);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h81, d_b);
        repeat (3) idle();
        check("wdog_p0_writes", p0_writes, 4);
        check("wdog_abort_pulses", abort_pulses, 1);
`endif

        // Randomized bursts with stalls, contention and garbage on idle ports
        do_reset();
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (rem[p] == 0 && $urandom_range(0, 3) == 0) rem[p] = $urandom_range(1, 7);
                rq[p] = (rem[p] > 0) && ($urandom_range(0, 4) != 0);
                lq[p] = rq[p] ? (rem[p] == 1) : 1'($urandom_range(0, 1));
                aq[p] = 8'($urandom_range(0, 255));
                dq[p] = {8{$urandom}};
            end
            own = m_owner;
            step(rq[0], lq[0], aq[0], dq[0], rq[1], lq[1], aq[1], dq[1]);
            if (own >= 0 && rq[own] && rem[own] > 0) rem[own]--;
        end
        repeat (3) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
